// File: rtl/jogo_pkg.sv
// Shared definitions for the 3x3 game: cell codes, controller states and the
// table of winning lines.
package jogo_pkg;

    localparam logic [1:0] VAZIO = 2'b00;
    localparam logic [1:0] X     = 2'b01;
    localparam logic [1:0] O     = 2'b10;

    localparam int unsigned N_CELLS = 9;
    localparam int unsigned N_LINES = 8;

    typedef enum logic [2:0] {
        INICIAL,
        LIMPA,
        ESPERA,
        VALIDA,
        VERIFICA,
        TROCA,
        INVALIDA,
        FIM
    } estado_t;

    // Rows, columns, then the two diagonals (row-major cell indices).
    localparam int unsigned WIN_LINES [N_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic logic [1:0] cell_at(input logic [17:0] tab, input logic [3:0] pos);
        logic [1:0] v;
        v = VAZIO;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            if (pos == 4'(i)) v = tab[2*i +: 2];
        end
        return v;
    endfunction

endpackage

// File: rtl/detector_vitoria.sv
// Combinational line/full-board detector: flags a completed line of the given
// symbol and whether every cell is occupied.
module detector_vitoria
    import jogo_pkg::*;
(
    input  logic [17:0] tabuleiro,
    input  logic [1:0]  simbolo,
    output logic        linha_ok,
    output logic        cheio
);

    always_comb begin
        linha_ok = 1'b0;
        cheio    = 1'b1;
        for (int unsigned l = 0; l < N_LINES; l++) begin
            if (simbolo != VAZIO &&
                tabuleiro[2*WIN_LINES[l][0] +: 2] == simbolo &&
                tabuleiro[2*WIN_LINES[l][1] +: 2] == simbolo &&
                tabuleiro[2*WIN_LINES[l][2] +: 2] == simbolo)
                linha_ok = 1'b1;
        end
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            if (tabuleiro[2*i +: 2] == VAZIO) cheio = 1'b0;
        end
    end

endmodule

// File: rtl/board_move_ctrl.sv
// Move controller for the 3x3 game: validates and writes moves into the board
// register, detects win/draw and drives the downstream turn-toggle flip-flop.
module board_move_ctrl
    import jogo_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        start,
    input  logic        jogar,
    input  logic [3:0]  posicao,
    input  logic [1:0]  jogador,
    output logic [17:0] tabuleiro,
    output logic        troca_jogador,
    output logic        limpa_jogador,
    output logic        jogada_invalida,
    output logic        tempo_esgotado,
    output logic        vitoria,
    output logic        empate,
    output logic [1:0]  vencedor,
    output logic        fim_jogo
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    estado_t       state_q, state_d;
    logic [17:0]   tab_q, tab_d;
    logic [3:0]    pos_q, pos_d;
    logic [1:0]    jog_q, jog_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tout_q, tout_d;
    logic          vit_q, vit_d;
    logic          emp_q, emp_d;
    logic [1:0]    venc_q, venc_d;
    logic          linha_ok, cheio;

    detector_vitoria u_detector (
        .tabuleiro (tab_q),
        .simbolo   (jog_q),
        .linha_ok  (linha_ok),
        .cheio     (cheio)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= INICIAL;
            tab_q   <= '0;
            pos_q   <= '0;
            jog_q   <= '0;
            timer_q <= '0;
            tout_q  <= 1'b0;
            vit_q   <= 1'b0;
            emp_q   <= 1'b0;
            venc_q  <= '0;
        end else begin
            state_q <= state_d;
            tab_q   <= tab_d;
            pos_q   <= pos_d;
            jog_q   <= jog_d;
            timer_q <= timer_d;
            tout_q  <= tout_d;
            vit_q   <= vit_d;
            emp_q   <= emp_d;
            venc_q  <= venc_d;
        end
    end

    // Timer is held at zero outside ESPERA, which gives the clear-on-entry behaviour.
    always_comb begin
        state_d = state_q;
        tab_d   = tab_q;
        pos_d   = pos_q;
        jog_d   = jog_q;
        timer_d = '0;
        tout_d  = 1'b0;
        vit_d   = vit_q;
        emp_d   = emp_q;
        venc_d  = venc_q;
        if (start) begin
            state_d = LIMPA;
            tab_d   = '0;
            vit_d   = 1'b0;
            emp_d   = 1'b0;
            venc_d  = VAZIO;
        end else begin
            case (state_q)
                INICIAL: state_d = INICIAL;
                LIMPA:   state_d = ESPERA;
                ESPERA: begin
                    if (jogar) begin
                        pos_d   = posicao;
                        jog_d   = jogador;
                        state_d = VALIDA;
                    end else if (TIMEOUT_CYCLES > 0 && timer_q == T_LAST) begin
                        tout_d  = 1'b1;
                        state_d = TROCA;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                VALIDA: begin
                    if (pos_q <= 4'd8 && cell_at(tab_q, pos_q) == VAZIO) begin
                        for (int unsigned i = 0; i < N_CELLS; i++) begin
                            if (pos_q == 4'(i)) tab_d[2*i +: 2] = jog_q;
                        end
                        state_d = VERIFICA;
                    end else begin
                        state_d = INVALIDA;
                    end
                end
                VERIFICA: begin
                    if (linha_ok) begin
                        vit_d   = 1'b1;
                        venc_d  = jog_q;
                        state_d = FIM;
                    end else if (cheio) begin
                        emp_d   = 1'b1;
                        venc_d  = VAZIO;
                        state_d = FIM;
                    end else begin
                        state_d = TROCA;
                    end
                end
                TROCA:    state_d = ESPERA;
                INVALIDA: state_d = ESPERA;
                FIM:      state_d = FIM;
                default:  state_d = INICIAL;
            endcase
        end
    end

    assign tabuleiro       = tab_q;
    assign troca_jogador   = (state_q == TROCA);
    assign tempo_esgotado  = (state_q == TROCA) && tout_q;
    assign limpa_jogador   = (state_q == LIMPA);
    assign jogada_invalida = (state_q == INVALIDA);
    assign fim_jogo        = (state_q == FIM);
    assign vitoria         = vit_q;
    assign empate          = emp_q;
    assign vencedor        = venc_q;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Directed testbench for board_move_ctrl: one instance without timeout, one with
// TIMEOUT_CYCLES=5, each feeding its own model of the turn-toggle flip-flop.
module tb_board_move_ctrl;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic        jogar = 1'b0;
    logic [3:0]  posicao = '0;

    logic [1:0]  jog0, jog1;
    logic [17:0] tab0, tab1;
    logic        troca0, limpa0, inv0, tout0, vit0, emp0, fim0;
    logic        troca1, limpa1, inv1, tout1, vit1, emp1, fim1;
    logic [1:0]  venc0, venc1;

    int tests = 0;
    int fails = 0;
    int n_troca, n_inv;

    always #5 clk = ~clk;

    board_move_ctrl u_dut0 (
        .clk(clk), .clear_n(clear_n), .start(start), .jogar(jogar), .posicao(posicao),
        .jogador(jog0), .tabuleiro(tab0), .troca_jogador(troca0), .limpa_jogador(limpa0),
        .jogada_invalida(inv0), .tempo_esgotado(tout0), .vitoria(vit0), .empate(emp0),
        .vencedor(venc0), .fim_jogo(fim0)
    );

    board_move_ctrl #(.TIMEOUT_CYCLES(5)) u_dut1 (
        .clk(clk), .clear_n(clear_n), .start(start), .jogar(jogar), .posicao(posicao),
        .jogador(jog1), .tabuleiro(tab1), .troca_jogador(troca1), .limpa_jogador(limpa1),
        .jogada_invalida(inv1), .tempo_esgotado(tout1), .vitoria(vit1), .empate(emp1),
        .vencedor(venc1), .fim_jogo(fim1)
    );

    // Downstream turn-toggle flip-flops
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n)    jog0 <= 2'b01;
        else if (limpa0) jog0 <= 2'b01;
        else if (troca0) jog0 <= ~jog0;
    end
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n)    jog1 <= 2'b01;
        else if (limpa1) jog1 <= 2'b01;
        else if (troca1) jog1 <= ~jog1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_game();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic play(input logic [3:0] p);
        n_troca = 0;
        n_inv   = 0;
        jogar   = 1'b1;
        posicao = p;
        step();
        jogar   = 1'b0;
        n_troca += int'(troca0);
        n_inv   += int'(inv0);
        repeat (3) begin
            step();
            n_troca += int'(troca0);
            n_inv   += int'(inv0);
        end
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({tab0, troca0, limpa0, inv0, tout0, vit0, emp0, venc0, fim0} !== 27'd0) begin
            fails++; $display("FAIL reset_outs0: got %0h expected 0",
                {tab0, troca0, limpa0, inv0, tout0, vit0, emp0, venc0, fim0});
        end
        tests++;
        if ({tab1, troca1, limpa1, inv1, tout1, vit1, emp1, venc1, fim1} !== 27'd0) begin
            fails++; $display("FAIL reset_outs1: got %0h expected 0",
                {tab1, troca1, limpa1, inv1, tout1, vit1, emp1, venc1, fim1});
        end
        @(negedge clk);
        clear_n = 1'b1;
        play(4'd4);
        tests++;
        if (tab0 !== 18'h0 || n_troca !== 0 || limpa0 !== 1'b0) begin
            fails++; $display("FAIL inicial_ignores_jogar: tab=%0h troca=%0d limpa=%b expected 0/0/0",
                tab0, n_troca, limpa0);
        end
    endtask

    task automatic test_first_move();
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (limpa0 !== 1'b1 || tab0 !== 18'h0) begin
            fails++; $display("FAIL limpa_pulse: limpa=%b tab=%0h expected 1/0", limpa0, tab0);
        end
        step();
        tests++;
        if (limpa0 !== 1'b0 || jog0 !== 2'b01) begin
            fails++; $display("FAIL limpa_once: limpa=%b jog=%b expected 0/01", limpa0, jog0);
        end
        jogar = 1'b1;
        posicao = 4'd4;
        step();
        jogar = 1'b0;
        tests++;
        if (tab0 !== 18'h0 || troca0 !== 1'b0) begin
            fails++; $display("FAIL valida_nowrite: tab=%0h troca=%b expected 0/0", tab0, troca0);
        end
        step();
        tests++;
        if (tab0 !== 18'h100 || troca0 !== 1'b0 || inv0 !== 1'b0) begin
            fails++; $display("FAIL write_cell4: tab=%0h troca=%b inv=%b expected 100/0/0",
                tab0, troca0, inv0);
        end
        step();
        tests++;
        if (troca0 !== 1'b1 || inv0 !== 1'b0 || limpa0 !== 1'b0 || tout0 !== 1'b0 || fim0 !== 1'b0) begin
            fails++; $display("FAIL troca_pulse: troca=%b inv=%b limpa=%b tout=%b fim=%b expected 1/0/0/0/0",
                troca0, inv0, limpa0, tout0, fim0);
        end
        step();
        tests++;
        if (troca0 !== 1'b0 || jog0 !== 2'b10) begin
            fails++; $display("FAIL troca_once: troca=%b jog=%b expected 0/10", troca0, jog0);
        end
    endtask

    task automatic test_invalid();
        play(4'd4);
        tests++;
        if (n_inv !== 1 || n_troca !== 0 || tab0 !== 18'h100) begin
            fails++; $display("FAIL invalid_occupied: inv=%0d troca=%0d tab=%0h expected 1/0/100",
                n_inv, n_troca, tab0);
        end
        play(4'd11);
        tests++;
        if (n_inv !== 1 || n_troca !== 0 || tab0 !== 18'h100 || jog0 !== 2'b10) begin
            fails++; $display("FAIL invalid_range: inv=%0d troca=%0d tab=%0h jog=%b expected 1/0/100/10",
                n_inv, n_troca, tab0, jog0);
        end
    endtask

    task automatic test_win();
        new_game();
        play(4'd0); play(4'd3); play(4'd1); play(4'd4);
        tests++;
        if (fim0 !== 1'b0 || jog0 !== 2'b01) begin
            fails++; $display("FAIL win_premature: fim=%b jog=%b expected 0/01", fim0, jog0);
        end
        play(4'd2);
        tests++;
        if (vit0 !== 1'b1 || venc0 !== 2'b01 || fim0 !== 1'b1 || emp0 !== 1'b0 || n_troca !== 0) begin
            fails++; $display("FAIL win_row0: vit=%b venc=%b fim=%b emp=%b troca=%0d expected 1/01/1/0/0",
                vit0, venc0, fim0, emp0, n_troca);
        end
        tests++;
        if (tab0 !== 18'h295) begin
            fails++; $display("FAIL win_board: got %0h expected 295", tab0);
        end
        play(4'd8);
        tests++;
        if (tab0 !== 18'h295 || fim0 !== 1'b1 || vit0 !== 1'b1 || n_troca !== 0 || n_inv !== 0) begin
            fails++; $display("FAIL fim_ignores_jogar: tab=%0h fim=%b vit=%b troca=%0d inv=%0d expected 295/1/1/0/0",
                tab0, fim0, vit0, n_troca, n_inv);
        end
    endtask

    task automatic test_draw();
        new_game();
        tests++;
        if (vit0 !== 1'b0 || venc0 !== 2'b00 || fim0 !== 1'b0 || tab0 !== 18'h0) begin
            fails++; $display("FAIL limpa_clears_result: vit=%b venc=%b fim=%b tab=%0h expected 0/00/0/0",
                vit0, venc0, fim0, tab0);
        end
        play(4'd0); play(4'd2); play(4'd1); play(4'd3); play(4'd5);
        play(4'd4); play(4'd6); play(4'd7); play(4'd8);
        tests++;
        if (emp0 !== 1'b1 || venc0 !== 2'b00 || vit0 !== 1'b0 || fim0 !== 1'b1 || n_troca !== 0) begin
            fails++; $display("FAIL draw: emp=%b venc=%b vit=%b fim=%b troca=%0d expected 1/00/0/1/0",
                emp0, venc0, vit0, fim0, n_troca);
        end
        tests++;
        if (tab0 !== 18'h196A5) begin
            fails++; $display("FAIL draw_board: got %0h expected 196a5", tab0);
        end
    endtask

    task automatic test_ninth_win();
        new_game();
        tests++;
        if (emp0 !== 1'b0) begin
            fails++; $display("FAIL limpa_clears_empate: got %b expected 0", emp0);
        end
        play(4'd0); play(4'd2); play(4'd1); play(4'd3); play(4'd4);
        play(4'd5); play(4'd6); play(4'd7);
        tests++;
        if (fim0 !== 1'b0 || jog0 !== 2'b01) begin
            fails++; $display("FAIL ninth_premature: fim=%b jog=%b expected 0/01", fim0, jog0);
        end
        play(4'd8);
        tests++;
        if (vit0 !== 1'b1 || emp0 !== 1'b0 || venc0 !== 2'b01 || fim0 !== 1'b1) begin
            fails++; $display("FAIL ninth_win: vit=%b emp=%b venc=%b fim=%b expected 1/0/01/1",
                vit0, emp0, venc0, fim0);
        end
    endtask

    task automatic test_timeout();
        new_game();
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c < 5) begin
                tests++;
                if (troca1 !== 1'b0 || tout1 !== 1'b0) begin
                    fails++; $display("FAIL timeout_early c=%0d: troca=%b tout=%b expected 0/0", c, troca1, tout1);
                end
            end else begin
                tests++;
                if (troca1 !== 1'b1 || tout1 !== 1'b1 || inv1 !== 1'b0) begin
                    fails++; $display("FAIL timeout_pulse: troca=%b tout=%b inv=%b expected 1/1/0", troca1, tout1, inv1);
                end
            end
        end
        step();
        tests++;
        if (troca1 !== 1'b0 || tout1 !== 1'b0 || jog1 !== 2'b10) begin
            fails++; $display("FAIL timeout_once: troca=%b tout=%b jog=%b expected 0/0/10", troca1, tout1, jog1);
        end
        repeat (4) step();
        jogar = 1'b1;
        posicao = 4'd0;
        step();
        jogar = 1'b0;
        tests++;
        if (troca1 !== 1'b0 || tout1 !== 1'b0) begin
            fails++; $display("FAIL jogar_beats_timeout: troca=%b tout=%b expected 0/0", troca1, tout1);
        end
        step();
        tests++;
        if (tab1 !== 18'h2) begin
            fails++; $display("FAIL timeout_move_write: got %0h expected 2", tab1);
        end
        step();
        tests++;
        if (troca1 !== 1'b1 || tout1 !== 1'b0) begin
            fails++; $display("FAIL timeout_move_troca: troca=%b tout=%b expected 1/0", troca1, tout1);
        end
    endtask

    task automatic test_abort();
        new_game();
        jogar = 1'b1;
        posicao = 4'd2;
        step();
        jogar = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (tab0 !== 18'h0 || limpa0 !== 1'b1 || troca0 !== 1'b0) begin
            fails++; $display("FAIL start_in_valida: tab=%0h limpa=%b troca=%b expected 0/1/0", tab0, limpa0, troca0);
        end
        step();
        tests++;
        if (tab0 !== 18'h0 || troca0 !== 1'b0) begin
            fails++; $display("FAIL start_no_write: tab=%0h troca=%b expected 0/0", tab0, troca0);
        end
        jogar = 1'b1;
        posicao = 4'd3;
        step();
        jogar = 1'b0;
        step();
        step();
        tests++;
        if (troca0 !== 1'b1 || tab0 !== 18'h40) begin
            fails++; $display("FAIL pre_reset_troca: troca=%b tab=%0h expected 1/40", troca0, tab0);
        end
        #2;
        clear_n = 1'b0;
        #1;
        tests++;
        if ({tab0, troca0, limpa0, inv0, tout0, vit0, emp0, venc0, fim0} !== 27'd0) begin
            fails++; $display("FAIL async_reset_outs: got %0h expected 0",
                {tab0, troca0, limpa0, inv0, tout0, vit0, emp0, venc0, fim0});
        end
        @(negedge clk);
        clear_n = 1'b1;
        step();
        tests++;
        if (troca0 !== 1'b0 || jog0 !== 2'b01 || tab0 !== 18'h0) begin
            fails++; $display("FAIL after_reset: troca=%b jog=%b tab=%0h expected 0/01/0", troca0, jog0, tab0);
        end
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_invalid();
        test_win();
        test_draw();
        test_ninth_win();
        test_timeout();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
